// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the BCD time-of-day keeper.
//   - BCD digit limits used by the digit counters and set-value validation
//   - FSM state type {RUN, SET}
//   - bcd_time_valid(): checks a BCD HH:MM:SS triple for legality
package rtc_pkg;

   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] SEC_MAX_TENS = 4'd5;
   localparam logic [7:0] HOUR_MAX     = 8'h23;

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } rtc_state_e;

   // Every digit must be decimal, minute/second tens at most 5, and the hour
   // at most 23. Once both hour digits are known to be decimal, a plain
   // numeric compare of the BCD byte orders the same way as the decimal value.
   function automatic logic bcd_time_valid(input logic [7:0] hh,
                                           input logic [7:0] mm,
                                           input logic [7:0] ss);
      logic digits_ok;
      digits_ok = (hh[7:4] <= DIGIT_MAX) && (hh[3:0] <= DIGIT_MAX) &&
                  (mm[7:4] <= DIGIT_MAX) && (mm[3:0] <= DIGIT_MAX) &&
                  (ss[7:4] <= DIGIT_MAX) && (ss[3:0] <= DIGIT_MAX);
      return digits_ok && (mm[7:4] <= SEC_MAX_TENS) &&
             (ss[7:4] <= SEC_MAX_TENS) && (hh <= HOUR_MAX);
   endfunction

endpackage

// File: rtl/rtc_time_keeper_bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit of the time-of-day counter.
//   clk_100MHz, rstn : clock, synchronous active-low reset (clears to 0)
//   max_val          : value after which the digit wraps to 0
//   inc              : advance by one this cycle
//   load, load_val   : parallel load (has priority over inc)
//   q                : current digit
//   carry            : inc is asserted while q == max_val (digit wraps now)
module bcd_digit_counter (
   input  logic       clk_100MHz,
   input  logic       rstn,
   input  logic [3:0] max_val,
   input  logic       inc,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] q,
   output logic       carry
);

   assign carry = inc && (q == max_val);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent behaviour.
   always_ff @(posedge clk_100MHz) begin
      if (!rstn)     q <= 4'd0;
      else if (load) q <= load_val;
      else if (inc)  q <= (q == max_val) ? 4'd0 : q + 4'd1;
   end

endmodule

// File: rtl/rtc_time_keeper.sv
// rtc_time_keeper: 24 h BCD time-of-day counter advanced by a slow,
// asynchronous square wave, with a valid/ready time-set port.
//   clk_100MHz, rstn           : clock, synchronous active-low reset
//   tick_in                    : divided square wave (asynchronous)
//   set_valid/set_ready        : time-set handshake
//   set_hh, set_mm, set_ss     : BCD value to load
//   set_err                    : pulse, accepted set value was illegal
//   hh_bcd, mm_bcd, ss_bcd     : current time, BCD
//   sec_pulse                  : pulse in the cycle the new time is visible
//   day_pulse                  : pulse on the 23:59:59 -> 00:00:00 wrap
module rtc_time_keeper
   import rtc_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int TICKS_PER_SEC = 1
) (
   input  logic       clk_100MHz,
   input  logic       rstn,
   input  logic       tick_in,
   input  logic       set_valid,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic       set_ready,
   output logic       set_err,
   output logic [7:0] hh_bcd,
   output logic [7:0] mm_bcd,
   output logic [7:0] ss_bcd,
   output logic       sec_pulse,
   output logic       day_pulse
);

   localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_q;
   logic [7:0]             presc_q;
   logic                   sec_ev;
   logic                   pending_q;
   rtc_state_e             state_q, next_state;
   logic                   accept, load, advance, cap_valid;
   logic [7:0]             cap_hh, cap_mm, cap_ss;

   // Digit order: 0 = ss units, 1 = ss tens, 2 = mm units, 3 = mm tens,
   // 4 = hh units, 5 = hh tens.
   logic [3:0] dig_q   [6];
   logic [3:0] dig_max [6];
   logic [3:0] dig_ld  [6];
   logic       dig_inc [6];
   logic       dig_cy  [6];

   // Synchronizer and rising-edge detector.
   always_ff @(posedge clk_100MHz) begin
      if (!rstn) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign sec_ev = edge_q && (presc_q == PRESC_LAST);

   always_ff @(posedge clk_100MHz) begin
      if (!rstn)       presc_q <= 8'd0;
      else if (edge_q) presc_q <= (presc_q == PRESC_LAST) ? 8'd0 : presc_q + 8'd1;
   end

   // NOTE: the captured set value is plain data qualified by the FSM state,
   // so it needs no reset; leaving it out keeps the flops simpler.
   always_ff @(posedge clk_100MHz) begin
      if (accept) begin
         cap_hh <= set_hh;
         cap_mm <= set_mm;
         cap_ss <= set_ss;
      end
   end

   assign cap_valid = bcd_time_valid(cap_hh, cap_mm, cap_ss);

   always_ff @(posedge clk_100MHz) begin
      if (!rstn) state_q <= RUN;
      else       state_q <= next_state;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state_q;
      set_ready  = 1'b0;
      set_err    = 1'b0;
      accept     = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      case (state_q)
         RUN: begin
            set_ready = 1'b1;
            if (set_valid) begin
               accept     = 1'b1;
               next_state = SET;
            end else begin
               advance = sec_ev || pending_q;
            end
         end
         SET: begin
            next_state = RUN;
            load       = cap_valid;
            set_err    = !cap_valid;
         end
         default: next_state = RUN;
      endcase
   end

   // A second arriving while a set is in flight is held and applied in the
   // first RUN cycle, on top of the loaded (or retained) time.
   always_ff @(posedge clk_100MHz) begin
      if (!rstn)                            pending_q <= 1'b0;
      else if (accept || (state_q == SET)) pending_q <= pending_q | sec_ev;
      else if (advance)                     pending_q <= 1'b0;
   end

   always_comb begin
      dig_max[0] = DIGIT_MAX;
      dig_max[1] = SEC_MAX_TENS;
      dig_max[2] = DIGIT_MAX;
      dig_max[3] = SEC_MAX_TENS;
      // Hours units stop at 3 only once the tens digit reaches 2.
      dig_max[4] = (dig_q[5] == HOUR_MAX[7:4]) ? HOUR_MAX[3:0] : DIGIT_MAX;
      dig_max[5] = HOUR_MAX[7:4];
      dig_ld[0]  = cap_ss[3:0];
      dig_ld[1]  = cap_ss[7:4];
      dig_ld[2]  = cap_mm[3:0];
      dig_ld[3]  = cap_mm[7:4];
      dig_ld[4]  = cap_hh[3:0];
      dig_ld[5]  = cap_hh[7:4];
      dig_inc[0] = advance;
      for (int i = 1; i < 6; i++) dig_inc[i] = dig_cy[i-1];
   end

   for (genvar g = 0; g < 6; g++) begin : g_digit
      bcd_digit_counter u_digit (
         .clk_100MHz (clk_100MHz),
         .rstn       (rstn),
         .max_val    (dig_max[g]),
         .inc        (dig_inc[g]),
         .load       (load),
         .load_val   (dig_ld[g]),
         .q          (dig_q[g]),
         .carry      (dig_cy[g])
      );
   end

   always_ff @(posedge clk_100MHz) begin
      if (!rstn) begin
         sec_pulse <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         sec_pulse <= advance;
         day_pulse <= dig_cy[5];
      end
   end

   assign hh_bcd = {dig_q[5], dig_q[4]};
   assign mm_bcd = {dig_q[3], dig_q[2]};
   assign ss_bcd = {dig_q[1], dig_q[0]};

endmodule

// File: tb/tb_rtc_time_keeper.sv
// tb_rtc_time_keeper: self-checking bench for rtc_time_keeper.
// The reference model keeps time as seconds-since-midnight and converts to
// BCD with plain division; set-value legality is decided on decoded values.
module tb_rtc_time_keeper;

   localparam int SYNC_STAGES = 2;

   logic       clk_100MHz = 1'b0;
   logic       rstn, tick_in, set_valid;
   logic [7:0] set_hh, set_mm, set_ss;
   logic       set_ready, set_err, sec_pulse, day_pulse;
   logic [7:0] hh_bcd, mm_bcd, ss_bcd;

   logic       tick4;
   logic       set_ready4, set_err4, sec_pulse4, day_pulse4;
   logic [7:0] hh4, mm4, ss4;

   int checks = 0;
   int errors = 0;
   int model_s;

   always #5 clk_100MHz = ~clk_100MHz;

   rtc_time_keeper #(.SYNC_STAGES(SYNC_STAGES), .TICKS_PER_SEC(1)) dut (
      .clk_100MHz (clk_100MHz), .rstn (rstn), .tick_in (tick_in),
      .set_valid (set_valid), .set_hh (set_hh), .set_mm (set_mm), .set_ss (set_ss),
      .set_ready (set_ready), .set_err (set_err),
      .hh_bcd (hh_bcd), .mm_bcd (mm_bcd), .ss_bcd (ss_bcd),
      .sec_pulse (sec_pulse), .day_pulse (day_pulse)
   );

   rtc_time_keeper #(.SYNC_STAGES(SYNC_STAGES), .TICKS_PER_SEC(4)) dut4 (
      .clk_100MHz (clk_100MHz), .rstn (rstn), .tick_in (tick4),
      .set_valid (1'b0), .set_hh (8'h00), .set_mm (8'h00), .set_ss (8'h00),
      .set_ready (set_ready4), .set_err (set_err4),
      .hh_bcd (hh4), .mm_bcd (mm4), .ss_bcd (ss4),
      .sec_pulse (sec_pulse4), .day_pulse (day_pulse4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic int dec(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit model_valid(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      if (hh[7:4] > 9 || hh[3:0] > 9 || mm[7:4] > 9 || mm[3:0] > 9 || ss[7:4] > 9 || ss[3:0] > 9)
         return 1'b0;
      return (dec(hh) < 24) && (dec(mm) < 60) && (dec(ss) < 60);
   endfunction

   function automatic logic [7:0] to_bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   task automatic check_time(input string tag);
      check(tag, 32'({hh_bcd, mm_bcd, ss_bcd}), 32'(model_bcd(model_s)));
   endtask

   // One rising edge on tick_in; watches a bounded window for the pulses.
   task automatic do_tick(input string tag);
      int pulses, days, stray, first;
      bit day_exp;
      pulses = 0; days = 0; stray = 0; first = 0;
      tick_in = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk_100MHz);
         if (sec_pulse) begin
            pulses++;
            if (first == 0) first = i;
         end
         if (day_pulse) days++;
         if (day_pulse && !sec_pulse) stray++;
      end
      tick_in = 1'b0;
      cyc(6);
      model_s = (model_s + 1) % 86400;
      day_exp = (model_s == 0);
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_latency"}, 32'(first), 32'(SYNC_STAGES + 2));
      check({tag, "_day"}, 32'(days), 32'(day_exp));
      check({tag, "_day_alone"}, 32'(stray), 32'd0);
      check_time({tag, "_time"});
   endtask

   task automatic do_set(input string tag, input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      bit v;
      v = model_valid(hh, mm, ss);
      check({tag, "_ready_before"}, 32'(set_ready), 32'd1);
      set_valid = 1'b1; set_hh = hh; set_mm = mm; set_ss = ss;
      @(negedge clk_100MHz);
      check({tag, "_ready_in_set"}, 32'(set_ready), 32'd0);
      check({tag, "_err_in_set"}, 32'(set_err), 32'(!v));
      set_valid = 1'b0;
      @(negedge clk_100MHz);
      check({tag, "_ready_after"}, 32'(set_ready), 32'd1);
      check({tag, "_err_after"}, 32'(set_err), 32'd0);
      if (v) model_s = dec(hh) * 3600 + dec(mm) * 60 + dec(ss);
      check_time({tag, "_time"});
   endtask

   initial begin
      int pulses4, edges4;
      rstn = 1'b0; tick_in = 1'b0; tick4 = 1'b0; set_valid = 1'b0;
      set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
      model_s = 0;
      cyc(3);
      check_time("reset_time");
      check("reset_ready", 32'(set_ready), 32'd1);
      check("reset_err", 32'(set_err), 32'd0);
      check("reset_sec", 32'(sec_pulse), 32'd0);
      check("reset_day", 32'(day_pulse), 32'd0);
      rstn = 1'b1;
      cyc(2);

      // Three seconds from reset.
      for (int i = 0; i < 3; i++) do_tick("tick3");
      check("after3", 32'({hh_bcd, mm_bcd, ss_bcd}), 32'h000003);

      // Midnight wrap.
      do_set("set_2359", 8'h23, 8'h59, 8'h58);
      do_tick("tick_5959");
      do_tick("tick_wrap");

      // Illegal value: time retained, set_err pulses.
      do_set("set_bad", 8'h24, 8'h5A, 8'h00);

      // Set accepted in the same cycle edge_q fires: tick is deferred.
      tick_in = 1'b1;
      cyc(SYNC_STAGES + 1);
      set_valid = 1'b1; set_hh = 8'h12; set_mm = 8'h34; set_ss = 8'h56;
      @(negedge clk_100MHz);
      check("coll_ready", 32'(set_ready), 32'd0);
      check("coll_sec_accept", 32'(sec_pulse), 32'd0);
      set_valid = 1'b0;
      @(negedge clk_100MHz);
      model_s = 12 * 3600 + 34 * 60 + 56;
      check_time("coll_loaded");
      check("coll_sec_set", 32'(sec_pulse), 32'd0);
      @(negedge clk_100MHz);
      check("coll_sec_adv", 32'(sec_pulse), 32'd1);
      model_s++;
      check_time("coll_time");
      tick_in = 1'b0;
      pulses4 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_100MHz);
         if (sec_pulse) pulses4++;
      end
      check("coll_no_extra", 32'(pulses4), 32'd0);

      // Randomized sets and ticks.
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0, 1: do_tick("rnd_tick");
            2: do_set("rnd_valid", to_bcd8($urandom_range(0, 23)),
                      to_bcd8($urandom_range(0, 59)), to_bcd8($urandom_range(0, 59)));
            default: do_set("rnd_raw", 8'($urandom_range(0, 255)),
                            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         endcase
      end

      // Reset during the SET cycle aborts the load.
      set_valid = 1'b1; set_hh = 8'h10; set_mm = 8'h20; set_ss = 8'h30;
      @(negedge clk_100MHz);
      rstn = 1'b0; set_valid = 1'b0;
      @(negedge clk_100MHz);
      model_s = 0;
      check_time("rst_set_time");
      check("rst_set_ready", 32'(set_ready), 32'd1);
      check("rst_set_err", 32'(set_err), 32'd0);
      rstn = 1'b1;
      cyc(2);

      // TICKS_PER_SEC = 4: seven edges give one second, the eighth a second one.
      pulses4 = 0;
      edges4 = 0;
      for (int e = 0; e < 7; e++) begin
         tick4 = 1'b1;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk_100MHz);
            if (sec_pulse4) pulses4++;
         end
         tick4 = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk_100MHz);
            if (sec_pulse4) pulses4++;
         end
         edges4++;
      end
      check("presc_pulses7", 32'(pulses4), 32'(edges4 / 4));
      check("presc_ss7", 32'(ss4), 32'(to_bcd8(edges4 / 4)));
      // Eighth edge, then tick held high: only that edge counts.
      tick4 = 1'b1;
      edges4++;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk_100MHz);
         if (sec_pulse4) pulses4++;
      end
      check("presc_pulses8", 32'(pulses4), 32'(edges4 / 4));
      check("stuck_ss", 32'(ss4), 32'(to_bcd8(edges4 / 4)));
      check("stuck_day", 32'(day_pulse4), 32'd0);
      tick4 = 1'b0;
      cyc(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
